// File: rtl/cpu_imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed, checksummed byte stream
// from the host, packs it little-endian into 32-bit words and holds the CPU until it verifies.
module cpu_imem_loader #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_WORDS      = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] imem_addr,
    output logic        imem_wrt_en,
    output logic [31:0] imem_wrt_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   MAX_LEN  = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        WRITE,
        CKSUM,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [15:0]   len;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    checksum;
    logic [TW-1:0] tmo_cnt;
    logic [23:0]   packer;

    logic          xfer;
    logic [15:0]   len_next;
    logic [15:0]   word_next;

    assign xfer      = in_valid & in_ready;
    assign len_next  = {in_data, len[7:0]};
    assign word_next = word_idx + 16'd1;

    // The fourth byte bypasses the packer so the word is ready on the strobe cycle right after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            imem_addr     <= '0;
            imem_wrt_en   <= 1'b0;
            imem_wrt_data <= '0;
            cpu_hold      <= 1'b1;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            len           <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            checksum      <= '0;
            tmo_cnt       <= '0;
            packer        <= '0;
        end else begin
            imem_wrt_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN_LO;
                        in_ready  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        cpu_hold  <= 1'b1;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                        checksum  <= '0;
                        tmo_cnt   <= '0;
                        packer    <= '0;
                    end
                end

                LEN_LO, LEN_HI, PAYLOAD, CKSUM: begin
                    if (!xfer) begin
                        if (tmo_cnt == TMO_LAST) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else begin
                        tmo_cnt <= '0;
                        case (state)
                            LEN_LO: begin
                                len[7:0] <= in_data;
                                state    <= LEN_HI;
                            end
                            LEN_HI: begin
                                len[15:8] <= in_data;
                                if ({1'b0, len_next} > MAX_LEN) begin
                                    state    <= ERR;
                                    in_ready <= 1'b0;
                                    load_err <= 1'b1;
                                end else if (len_next == 16'd0) begin
                                    state <= CKSUM;
                                end else begin
                                    state <= PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                checksum <= checksum + in_data;
                                byte_idx <= byte_idx + 2'd1;
                                case (byte_idx)
                                    2'd0: packer[7:0]   <= in_data;
                                    2'd1: packer[15:8]  <= in_data;
                                    2'd2: packer[23:16] <= in_data;
                                    default: begin
                                        state         <= WRITE;
                                        in_ready      <= 1'b0;
                                        imem_wrt_en   <= 1'b1;
                                        imem_addr     <= {word_idx[13:0], 2'b00};
                                        imem_wrt_data <= {in_data, packer};
                                    end
                                endcase
                            end
                            CKSUM: begin
                                in_ready <= 1'b0;
                                if (in_data == checksum) begin
                                    state     <= DONE;
                                    load_done <= 1'b1;
                                    cpu_hold  <= 1'b0;
                                end else begin
                                    state    <= ERR;
                                    load_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                WRITE: begin
                    word_idx <= word_next;
                    in_ready <= 1'b1;
                    state    <= (word_next == len) ? CKSUM : PAYLOAD;
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_imem_loader.sv
// Randomized scoreboard bench for cpu_imem_loader: a stream-level model predicts the
// memory writes and final status, a monitor checks them as the DUT produces them.
module tb_cpu_imem_loader;

    localparam int TIMEOUT_CYCLES = 1024;
    localparam int MAX_WORDS      = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [15:0] imem_addr;
    logic        imem_wrt_en;
    logic [31:0] imem_wrt_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    cpu_imem_loader #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_WORDS     (MAX_WORDS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_addr    (imem_addr),
        .imem_wrt_en  (imem_wrt_en),
        .imem_wrt_data(imem_wrt_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    localparam logic [2:0] ST_DONE = 3'b100;
    localparam logic [2:0] ST_ERR  = 3'b011;

    wr_t        exp_wr[$];
    logic [2:0] exp_status[$];
    wr_t        mon_wr;
    logic [2:0] mon_st;
    logic       prev_wr = 1'b0;
    logic       prev_stat = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;
    bit         gaps_on = 1'b0;
    bit         stuck = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    // Monitor: pops the scoreboard on every write strobe and on every new final status.
    always @(negedge clk) begin
        if (imem_wrt_en) begin
            checkOutput("in_ready_during_write", 32'(in_ready), 32'd0);
            checkOutput("single_cycle_strobe", 32'(prev_wr), 32'd0);
            if (exp_wr.size() == 0) begin
                reportFail("unexpected_write");
            end else begin
                mon_wr = exp_wr.pop_front();
                checkOutput("write_addr", 32'(imem_addr), 32'(mon_wr.addr));
                checkOutput("write_data", imem_wrt_data, mon_wr.data);
            end
        end
        if ((load_done | load_err) && !prev_stat) begin
            if (exp_status.size() == 0) begin
                reportFail("unexpected_status");
            end else begin
                mon_st = exp_status.pop_front();
                checkOutput("final_status", 32'({load_done, load_err, cpu_hold}), 32'(mon_st));
            end
        end
        prev_wr   <= imem_wrt_en;
        prev_stat <= load_done | load_err;
    end

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_wrt_en"}, 32'(imem_wrt_en), 32'd0);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "_data"}, imem_wrt_data, 32'd0);
        checkOutput({tag, "_flags"}, 32'({load_done, load_err, cpu_hold}), 32'b001);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was transferred.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   waited;
        bit   ok;
        waited = 0;
        ok = 1'b0;
        if (stuck) return;
        if (gaps_on && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && waited < 100) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            else waited++;
            @(negedge clk);
        end
        if (!ok) begin
            stuck = 1'b1;
            in_valid = 1'b0;
            checkOutput("byte_accepted", 32'(ok), 32'd1);
        end
    endtask

    task automatic wait_status();
        int n;
        n = 0;
        while (!(load_done | load_err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(load_done | load_err))
            checkOutput("status_reached", 32'(load_done | load_err), 32'd1);
        @(negedge clk);
    endtask

    // Reference model: words are consecutive groups of four bytes, checksum is the byte sum mod 256.
    task automatic applyStimulus(input logic [15:0] len, input logic [7:0] payload[$],
                                 input logic [7:0] ck);
        int sum;
        stuck = 1'b0;
        if (int'(len) > MAX_WORDS) begin
            exp_status.push_back(ST_ERR);
        end else begin
            sum = 0;
            for (int w = 0; w < int'(len); w++)
                exp_wr.push_back({16'(w * 4), payload[4*w+3], payload[4*w+2],
                                  payload[4*w+1], payload[4*w]});
            foreach (payload[i]) sum += int'(payload[i]);
            exp_status.push_back(((sum % 256) == int'(ck)) ? ST_DONE : ST_ERR);
        end
        pulse_start();
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (int'(len) <= MAX_WORDS) begin
            foreach (payload[i]) send_byte(payload[i]);
            send_byte(ck);
        end
        in_valid = 1'b0;
        wait_status();
        checkOutput("writes_pending", 32'(exp_wr.size()), 32'd0);
        checkOutput("status_pending", 32'(exp_status.size()), 32'd0);
    endtask

    logic [7:0] basic[$];
    logic [7:0] empty_q[$];
    logic [7:0] rnd[$];

    initial begin
        basic = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        empty_q = {};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Payload bytes of the basic image sum to 0xB8.
        applyStimulus(16'd2, basic, 8'hB8);
        applyStimulus(16'd2, basic, 8'h99);
        applyStimulus(16'd2, basic, 8'hB8);

        applyStimulus(16'd0, empty_q, 8'h00);
        applyStimulus(16'h4001, empty_q, 8'h00);
        checkOutput("in_ready_in_err", 32'(in_ready), 32'd0);

        gaps_on = 1'b1;
        applyStimulus(16'd2, basic, 8'hB8);

        for (int t = 0; t < 10; t++) begin
            int len;
            int s;
            len = $urandom_range(0, 5);
            rnd = {};
            s = 0;
            for (int i = 0; i < 4 * len; i++) begin
                rnd.push_back(8'($urandom));
                s += int'(rnd[i]);
            end
            gaps_on = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                applyStimulus(16'(len), rnd, 8'(s) ^ 8'(1 << $urandom_range(0, 7)));
            else
                applyStimulus(16'(len), rnd, 8'(s));
        end

        gaps_on = 1'b0;
        stuck = 1'b0;
        exp_status.push_back(ST_ERR);
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        in_valid = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        checkOutput("timeout_early", 32'(load_err), 32'd0);
        @(negedge clk);
        checkOutput("timeout_at_limit", 32'(load_err), 32'd1);
        wait_status();
        checkOutput("timeout_no_write", 32'(exp_wr.size()), 32'd0);

        exp_wr.push_back({16'h0000, 32'h44332211});
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(basic[i]);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midreset_writes", 32'(exp_wr.size()), 32'd0);
        applyStimulus(16'd2, basic, 8'hB8);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
